// File: rtl/alu_pipe_pkg.sv
// Shared encodings for the integer execution unit: unit id, sub-unit/operation selects
// and the per-entry flag bundle carried through the result queue.
package alu_pipe_pkg;

    localparam logic [1:0] UNIT_ALU = 2'd0;

    typedef enum logic [2:0] {
        SU_UPPER  = 3'd0,
        SU_BRANCH = 3'd1,
        SU_ADDSUB = 3'd2,
        SU_LOGIC  = 3'd3,
        SU_SHIFT  = 3'd4
    } sub_unit_e;

    typedef enum logic [3:0] {
        UP_LUI   = 4'd0,
        UP_AUIPC = 4'd1,
        UP_JAL   = 4'd2,
        UP_JALR  = 4'd3
    } upper_sel_e;

    typedef enum logic [3:0] {
        BR_EQ  = 4'd0,
        BR_NE  = 4'd1,
        BR_LT  = 4'd2,
        BR_GE  = 4'd3,
        BR_LTU = 4'd4,
        BR_GEU = 4'd5
    } branch_sel_e;

    typedef enum logic [3:0] {
        AS_ADD = 4'd0,
        AS_SUB = 4'd1
    } addsub_sel_e;

    typedef enum logic [3:0] {
        LG_SLT  = 4'd0,
        LG_SLTU = 4'd1,
        LG_XOR  = 4'd2,
        LG_OR   = 4'd3,
        LG_AND  = 4'd4
    } logic_sel_e;

    typedef enum logic [3:0] {
        SH_SLL = 4'd0,
        SH_SRL = 4'd1,
        SH_SRA = 4'd2
    } shift_sel_e;

    // Width-independent part of a queue entry; the XLEN-wide result/target
    // fields are appended by the unit that knows XLEN.
    typedef struct packed {
        logic       target_valid;
        logic       result_valid;
        logic       illegal;
        logic [4:0] rd;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_queue.sv
// Circular result queue with explicit occupancy count; push, pop and flush,
// with push+pop on a full queue allowed in the same cycle.
module exec_queue #(
    parameter type entry_t = logic,
    parameter int  DEPTH   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    input  logic   flush_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [CW-1:0]   count_q;
    logic            doPush;
    logic            doPop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPop   = pop_i && !empty_o && !flush_i;
    assign doPush  = push_i && !flush_i && (!full_o || doPop);
    assign data_o  = mem_q[rdPtr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
            if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer execution unit: decode/compute, optional iterative shifter and
// a DEPTH-entry result queue between issue and write-back.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int         XLEN       = 32,
    parameter int         DEPTH      = 2,
    parameter int         SHIFT_STEP = 32,
    parameter logic [1:0] UNIT_ID    = UNIT_ALU
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      unit,
    input  logic [2:0]      sub_unit,
    input  logic [3:0]      sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] immediate,
    input  logic            imm,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd_i,
    output logic            ok_o,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o,
    output logic            illegal,
    output logic [XLEN-1:0] target,
    output logic            target_valid,
    output logic            out_valid,
    input  logic            ok_i,
    input  logic            flush
);

    localparam int              SHW  = $clog2(XLEN);
    localparam bit              ITER = (SHIFT_STEP < XLEN);
    localparam logic [SHW-1:0]  STEP = SHW'(SHIFT_STEP % XLEN);

    typedef struct packed {
        alu_flags_t      flags;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] target;
    } entry_t;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e          state_q;
    logic [XLEN-1:0] shVal_q;
    logic [SHW-1:0]  shRem_q;
    logic [3:0]      shOp_q;
    logic [4:0]      shRd_q;

    logic            full;
    logic            empty;
    logic            accept;
    logic            pushEn;
    logic            popEn;
    logic            decShift;
    logic            startShift;
    logic            taken;
    logic            ill;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] pcPlus4;
    logic [XLEN-1:0] brTarget;
    logic [XLEN-1:0] shNext;
    logic [SHW-1:0]  shamt;
    logic [SHW-1:0]  step;
    logic [SHW-1:0]  remNext;
    entry_t          decEntry;
    entry_t          pushEntry;
    entry_t          headEntry;

    assign ok_o       = (state_q == IDLE) && !full && !flush;
    assign accept     = (unit == UNIT_ID) && ok_o;
    assign opb        = (imm && sub_unit != SU_BRANCH) ? immediate : rs2;
    assign shamt      = opb[SHW-1:0];
    assign pcPlus4    = pc + XLEN'(4);
    assign brTarget   = pc + immediate;
    assign startShift = ITER && decShift && (shamt != '0);

    always_comb begin
        decEntry          = '0;
        decEntry.flags.rd = rd_i;
        decShift          = 1'b0;
        taken             = 1'b0;
        ill               = 1'b0;
        case (sub_unit)
            SU_UPPER: begin
                decEntry.flags.result_valid = 1'b1;
                case (sel)
                    UP_LUI:   decEntry.result = immediate;
                    UP_AUIPC: decEntry.result = brTarget;
                    UP_JAL: begin
                        decEntry.result             = pcPlus4;
                        decEntry.target             = brTarget;
                        decEntry.flags.target_valid = 1'b1;
                    end
                    UP_JALR: begin
                        decEntry.result             = pcPlus4;
                        decEntry.target             = (rs1 + immediate) & ~XLEN'(1);
                        decEntry.flags.target_valid = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            SU_BRANCH: begin
                case (sel)
                    BR_EQ:   taken = (rs1 == rs2);
                    BR_NE:   taken = (rs1 != rs2);
                    BR_LT:   taken = ($signed(rs1) <  $signed(rs2));
                    BR_GE:   taken = ($signed(rs1) >= $signed(rs2));
                    BR_LTU:  taken = (rs1 <  rs2);
                    BR_GEU:  taken = (rs1 >= rs2);
                    default: ill = 1'b1;
                endcase
                if (taken) begin
                    decEntry.target             = brTarget;
                    decEntry.flags.target_valid = 1'b1;
                end
            end
            SU_ADDSUB: begin
                decEntry.flags.result_valid = 1'b1;
                case (sel)
                    AS_ADD:  decEntry.result = rs1 + opb;
                    AS_SUB: begin
                        if (imm) ill = 1'b1;
                        else     decEntry.result = rs1 - opb;
                    end
                    default: ill = 1'b1;
                endcase
            end
            SU_LOGIC: begin
                decEntry.flags.result_valid = 1'b1;
                case (sel)
                    LG_SLT:  decEntry.result = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(opb))};
                    LG_SLTU: decEntry.result = {{(XLEN-1){1'b0}}, (rs1 < opb)};
                    LG_XOR:  decEntry.result = rs1 ^ opb;
                    LG_OR:   decEntry.result = rs1 | opb;
                    LG_AND:  decEntry.result = rs1 & opb;
                    default: ill = 1'b1;
                endcase
            end
            SU_SHIFT: begin
                decEntry.flags.result_valid = 1'b1;
                decShift                    = 1'b1;
                case (sel)
                    SH_SLL:  decEntry.result = rs1 << shamt;
                    SH_SRL:  decEntry.result = rs1 >> shamt;
                    SH_SRA:  decEntry.result = $signed(rs1) >>> shamt;
                    default: begin
                        ill      = 1'b1;
                        decShift = 1'b0;
                    end
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            decEntry               = '0;
            decEntry.flags.rd      = rd_i;
            decEntry.flags.illegal = 1'b1;
        end
    end

    // Iterative shifter: each cycle consumes up to STEP bits of the remaining amount.
    assign step    = (shRem_q > STEP) ? STEP : shRem_q;
    assign remNext = shRem_q - step;

    always_comb begin
        case (shOp_q)
            SH_SLL:  shNext = shVal_q << step;
            SH_SRL:  shNext = shVal_q >> step;
            SH_SRA:  shNext = $signed(shVal_q) >>> step;
            default: shNext = shVal_q;
        endcase
    end

    always_comb begin
        pushEntry = decEntry;
        pushEn    = 1'b0;
        if (state_q == SHIFT) begin
            pushEntry                    = '0;
            pushEntry.flags.result_valid = 1'b1;
            pushEntry.flags.rd           = shRd_q;
            pushEntry.result             = shNext;
            pushEn                       = (remNext == '0) && !full && !flush;
        end else begin
            pushEn = accept && !startShift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shVal_q <= '0;
            shRem_q <= '0;
            shOp_q  <= '0;
            shRd_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && startShift) begin
                        state_q <= SHIFT;
                        shVal_q <= rs1;
                        shRem_q <= shamt;
                        shOp_q  <= sel;
                        shRd_q  <= rd_i;
                    end
                end
                SHIFT: begin
                    shVal_q <= shNext;
                    shRem_q <= remNext;
                    if (pushEn) state_q <= IDLE;
                end
            endcase
        end
    end

    assign popEn = !empty && ok_i && !flush;

    exec_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) uQueue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pushEn),
        .data_i  (pushEntry),
        .pop_i   (popEn),
        .flush_i (flush),
        .data_o  (headEntry),
        .full_o  (full),
        .empty_o (empty)
    );

    // Head fields are forced to zero whenever the queue is empty.
    assign out_valid    = !empty;
    assign result_valid = out_valid && headEntry.flags.result_valid;
    assign target_valid = out_valid && headEntry.flags.target_valid;
    assign illegal      = out_valid && headEntry.flags.illegal;
    assign rd_o         = out_valid ? headEntry.flags.rd : '0;
    assign result       = out_valid ? headEntry.result : '0;
    assign target       = out_valid ? headEntry.target : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (XLEN=32, DEPTH=2, SHIFT_STEP=4): directed ops push
// hand-computed expectations, a negedge monitor checks each entry as it is popped.
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;
    logic [1:0]  unit;
    logic [2:0]  sub_unit;
    logic [3:0]  sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] immediate;
    logic        imm;
    logic [31:0] pc;
    logic [4:0]  rd_i;
    logic        ok_o;
    logic        result_valid;
    logic [31:0] result;
    logic [4:0]  rd_o;
    logic        illegal;
    logic [31:0] target;
    logic        target_valid;
    logic        out_valid;
    logic        ok_i;
    logic        flush;

    typedef struct {
        logic        rv;
        logic [31:0] res;
        logic        tv;
        logic [31:0] tgt;
        logic        ill;
        logic [4:0]  rd;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    alu_pipe #(
        .XLEN       (32),
        .DEPTH      (2),
        .SHIFT_STEP (4),
        .UNIT_ID    (2'd0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .unit         (unit),
        .sub_unit     (sub_unit),
        .sel          (sel),
        .rs1          (rs1),
        .rs2          (rs2),
        .immediate    (immediate),
        .imm          (imm),
        .pc           (pc),
        .rd_i         (rd_i),
        .ok_o         (ok_o),
        .result_valid (result_valid),
        .result       (result),
        .rd_o         (rd_o),
        .illegal      (illegal),
        .target       (target),
        .target_valid (target_valid),
        .out_valid    (out_valid),
        .ok_i         (ok_i),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1);
    end

    function automatic exp_t mk(input logic rv, input logic [31:0] res, input logic tv,
                                input logic [31:0] tgt, input logic ill, input logic [4:0] rd);
        exp_t e;
        e.rv  = rv;
        e.res = res;
        e.tv  = tv;
        e.tgt = tgt;
        e.ill = ill;
        e.rd  = rd;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act !== want) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_ok_o"}, {31'b0, ok_o}, 32'd1);
        checkOutput({pfx, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        checkOutput({pfx, "_result_valid"}, {31'b0, result_valid}, 32'd0);
        checkOutput({pfx, "_result"}, result, 32'd0);
        checkOutput({pfx, "_rd_o"}, {27'b0, rd_o}, 32'd0);
        checkOutput({pfx, "_illegal"}, {31'b0, illegal}, 32'd0);
        checkOutput({pfx, "_target"}, target, 32'd0);
        checkOutput({pfx, "_target_valid"}, {31'b0, target_valid}, 32'd0);
    endtask

    // Present one request, wait (bounded) for acceptance, record its expectation.
    task automatic applyStimulus(input logic [2:0] su, input logic [3:0] sl,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic useImm, input logic [31:0] immv,
                                 input logic [31:0] pcv, input logic [4:0] rd, input exp_t e);
        bit acc;
        acc       = 1'b0;
        unit      = 2'd0;
        sub_unit  = su;
        sel       = sl;
        rs1       = a;
        rs2       = b;
        imm       = useImm;
        immediate = immv;
        pc        = pcv;
        rd_i      = rd;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ok_o) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            expQ.push_back(e);
        end else begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: got ok_o=0 for 40 cycles, expected acceptance of rd %0d", rd);
        end
        @(posedge clk);
        #1;
        unit = 2'd3;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s: got %0d pending entries, expected 0", name, expQ.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every popped head entry is compared against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && ok_i && !flush) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_entry: got rd %0d result 0x%08h, expected no entry", rd_o, result);
            end else begin
                e = expQ.pop_front();
                checkOutput("rd_o", {27'b0, rd_o}, {27'b0, e.rd});
                checkOutput("result_valid", {31'b0, result_valid}, {31'b0, e.rv});
                checkOutput("illegal", {31'b0, illegal}, {31'b0, e.ill});
                checkOutput("target_valid", {31'b0, target_valid}, {31'b0, e.tv});
                if (e.rv || e.ill) checkOutput("result", result, e.res);
                if (e.tv) checkOutput("target", target, e.tgt);
            end
        end
    end

    initial begin
        rst_n = 1'b0; unit = 2'd3; sub_unit = '0; sel = '0; rs1 = '0; rs2 = '0;
        immediate = '0; imm = 1'b0; pc = '0; rd_i = '0; ok_i = 1'b0; flush = 1'b0;
        #2;
        checkReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ok_i = 1'b1;

        // Arithmetic, branches, upper/jump, logic, illegal
        applyStimulus(3'd2, 4'd0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFD, 32'd0, 5'd7, mk(1, 32'd2, 0, 0, 0, 5'd7));
        applyStimulus(3'd2, 4'd1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0, 5'd1, mk(1, 32'hFFFF_FFFE, 0, 0, 0, 5'd1));
        applyStimulus(3'd2, 4'd1, 32'd3, 32'd5, 1'b1, 32'd9, 32'd0, 5'd2, mk(0, 32'd0, 0, 0, 1, 5'd2));
        applyStimulus(3'd1, 4'd4, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h20, 32'h100, 5'd3, mk(0, 0, 1, 32'h120, 0, 5'd3));
        applyStimulus(3'd1, 4'd2, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h20, 32'h100, 5'd4, mk(0, 0, 0, 0, 0, 5'd4));
        applyStimulus(3'd1, 4'd0, 32'd7, 32'd7, 1'b0, 32'hFFFF_FFF0, 32'h40, 5'd5, mk(0, 0, 1, 32'h30, 0, 5'd5));
        applyStimulus(3'd1, 4'd5, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h20, 32'h100, 5'd6, mk(0, 0, 0, 0, 0, 5'd6));
        applyStimulus(3'd0, 4'd2, 32'd0, 32'd0, 1'b0, 32'h10, 32'hFFFF_FFFC, 5'd1, mk(1, 32'd0, 1, 32'hC, 0, 5'd1));
        applyStimulus(3'd0, 4'd3, 32'h1001, 32'd0, 1'b0, 32'h4, 32'h200, 5'd2, mk(1, 32'h204, 1, 32'h1004, 0, 5'd2));
        applyStimulus(3'd0, 4'd0, 32'd0, 32'd0, 1'b0, 32'hABCD_E000, 32'h500, 5'd3, mk(1, 32'hABCD_E000, 0, 0, 0, 5'd3));
        applyStimulus(3'd0, 4'd1, 32'd0, 32'd0, 1'b0, 32'h2000, 32'h1000, 5'd4, mk(1, 32'h3000, 0, 0, 0, 5'd4));
        applyStimulus(3'd3, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 5'd5, mk(1, 32'd1, 0, 0, 0, 5'd5));
        applyStimulus(3'd3, 4'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 5'd6, mk(1, 32'd0, 0, 0, 0, 5'd6));
        applyStimulus(3'd3, 4'd2, 32'h0F0F, 32'd0, 1'b1, 32'hFF, 32'd0, 5'd7, mk(1, 32'h0FF0, 0, 0, 0, 5'd7));
        applyStimulus(3'd3, 4'd3, 32'hF0, 32'h0F, 1'b0, 32'd0, 32'd0, 5'd8, mk(1, 32'hFF, 0, 0, 0, 5'd8));
        applyStimulus(3'd3, 4'd4, 32'hF0F0, 32'hFF00, 1'b0, 32'd0, 32'd0, 5'd9, mk(1, 32'hF000, 0, 0, 0, 5'd9));
        applyStimulus(3'd5, 4'd0, 32'd1, 32'd2, 1'b0, 32'd0, 32'd0, 5'd10, mk(0, 32'd0, 0, 0, 1, 5'd10));
        drain("drain_basic");

        // Iterative shifts: shamt 8 at 4 bits/cycle keeps ok_o low for two cycles
        applyStimulus(3'd4, 4'd2, 32'h8000_0000, 32'h108, 1'b0, 32'd0, 32'd0, 5'd11, mk(1, 32'hFF80_0000, 0, 0, 0, 5'd11));
        @(negedge clk);
        checkOutput("sra_busy1_ok_o", {31'b0, ok_o}, 32'd0);
        @(negedge clk);
        checkOutput("sra_busy2_ok_o", {31'b0, ok_o}, 32'd0);
        @(negedge clk);
        checkOutput("sra_done_ok_o", {31'b0, ok_o}, 32'd1);
        checkOutput("sra_done_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(3'd4, 4'd1, 32'h8000_0000, 32'd8, 1'b0, 32'd0, 32'd0, 5'd12, mk(1, 32'h0080_0000, 0, 0, 0, 5'd12));
        @(negedge clk);
        checkOutput("srl_busy_ok_o", {31'b0, ok_o}, 32'd0);
        applyStimulus(3'd4, 4'd0, 32'd3, 32'd0, 1'b1, 32'd5, 32'd0, 5'd13, mk(1, 32'h60, 0, 0, 0, 5'd13));
        applyStimulus(3'd4, 4'd0, 32'h1234, 32'd0, 1'b0, 32'd0, 32'd0, 5'd14, mk(1, 32'h1234, 0, 0, 0, 5'd14));
        @(negedge clk);
        checkOutput("shamt0_ok_o", {31'b0, ok_o}, 32'd1);
        checkOutput("shamt0_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(3'd4, 4'd0, 32'd1, 32'd31, 1'b0, 32'd0, 32'd0, 5'd15, mk(1, 32'h8000_0000, 0, 0, 0, 5'd15));
        drain("drain_shift");

        // Back-pressure: two entries fill the queue, third waits until write-back resumes
        ok_i = 1'b0;
        applyStimulus(3'd2, 4'd0, 32'd10, 32'd0, 1'b1, 32'd1, 32'd0, 5'd16, mk(1, 32'd11, 0, 0, 0, 5'd16));
        applyStimulus(3'd2, 4'd0, 32'd20, 32'd0, 1'b1, 32'd2, 32'd0, 5'd17, mk(1, 32'd22, 0, 0, 0, 5'd17));
        @(negedge clk);
        checkOutput("full_ok_o", {31'b0, ok_o}, 32'd0);
        checkOutput("full_out_valid", {31'b0, out_valid}, 32'd1);
        fork
            begin
                @(posedge clk);
                #1;
                ok_i = 1'b1;
            end
        join_none
        applyStimulus(3'd2, 4'd0, 32'd30, 32'd0, 1'b1, 32'd3, 32'd0, 5'd18, mk(1, 32'd33, 0, 0, 0, 5'd18));
        drain("drain_full");

        // Flush with one queued entry and a shift in progress
        ok_i = 1'b0;
        applyStimulus(3'd2, 4'd0, 32'd100, 32'd0, 1'b1, 32'd1, 32'd0, 5'd19, mk(1, 32'd101, 0, 0, 0, 5'd19));
        applyStimulus(3'd4, 4'd0, 32'd1, 32'd31, 1'b0, 32'd0, 32'd0, 5'd20, mk(1, 32'h8000_0000, 0, 0, 0, 5'd20));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush_ok_o", {31'b0, ok_o}, 32'd1);
        checkOutput("flush_result", result, 32'd0);
        ok_i = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("flush_no_stale", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a shift
        applyStimulus(3'd4, 4'd0, 32'd1, 32'd31, 1'b0, 32'd0, 32'd0, 5'd21, mk(1, 32'h8000_0000, 0, 0, 0, 5'd21));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkReset("rst_mid");
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("rst_no_stale", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(3'd2, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 32'd0, 5'd22, mk(1, 32'd0, 0, 0, 0, 5'd22));
        drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
